seg_scan_driver: RTL and testbench

Multiplexed 4-digit seven-segment display driver for the MiniCalculator top level. It drives the board outputs seg_o/an_o from a 16-bit hex value supplied by the calculator core. The value is double-buffered: the core posts a new value at any time with a load strobe, and the driver applies it only at a frame boundary, so a frame never mixes digits from two values. Optional leading-zero blanking is supported.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/hex7seg.sv | 19 +
 rtl/seg_scan_driver.sv | 97 +++++++++
 tb/tb_seg_scan_driver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
//------------------------------------------------------------------------------
// Module : seg_pkg
// Brief  : Shared types and active-low seven-segment constants.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // {g,f,e,d,c,b,a}, active-low, glyphs 0..F
  localparam seg_t SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

`default_nettype wire

// File: rtl/hex7seg.sv
//------------------------------------------------------------------------------
// Module : hex7seg
// Brief  : Combinational nibble to active-low seven-segment decoder.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hex7seg
  import seg_pkg::*;
(
  input  nibble_t nib,
  output seg_t    seg
);

  assign seg = SEG_HEX[nib];

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
//------------------------------------------------------------------------------
// Module : seg_scan_driver
// Brief  : 4-digit multiplexed seven-segment scanner with frame-aligned
//          double-buffered value and optional leading-zero blanking.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] val_i,
  input  logic        load_i,
  input  logic        lz_en_i,
  output logic        ack_o,
  output logic        pend_o,
  output logic [6:0]  seg_o,
  output logic [3:0]  an_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      active;
  logic [15:0]      shadow;
  logic             pend;

  logic             tc;
  logic             boundary;
  nibble_t          cur_nib;
  seg_t             cur_seg;
  logic [3:0]       blank_mask;
  logic             cur_blank;

  assign tc       = (cnt == CNT_LAST);
  assign boundary = tc && (idx == 2'd3);
  assign cur_nib  = active[{idx, 2'b00} +: 4];

  // A digit is blank only if it and every more-significant nibble is zero.
  assign blank_mask[3] = (active[15:12] == 4'h0);
  assign blank_mask[2] = blank_mask[3] && (active[11:8] == 4'h0);
  assign blank_mask[1] = blank_mask[2] && (active[7:4]  == 4'h0);
  assign blank_mask[0] = 1'b0;
  assign cur_blank     = lz_en_i && blank_mask[idx];

  assign ack_o  = boundary && (pend || load_i);
  assign pend_o = pend;

  hex7seg u_dec (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= 2'd0;
      active <= 16'h0000;
      shadow <= 16'h0000;
      pend   <= 1'b0;
      seg_o  <= SEG_BLANK;
      an_o   <= AN_OFF;
    end else begin
      if (tc) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // A strobe landing on the boundary itself bypasses the shadow wait.
      if (boundary && load_i) begin
        active <= val_i;
        shadow <= val_i;
        pend   <= 1'b0;
      end else if (boundary && pend) begin
        active <= shadow;
        pend   <= 1'b0;
      end else if (load_i) begin
        shadow <= val_i;
        pend   <= 1'b1;
      end

      an_o  <= ~(4'b0001 << idx);
      seg_o <= cur_blank ? SEG_BLANK : cur_seg;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
//------------------------------------------------------------------------------
// Module : tb_seg_scan_driver
// Brief  : Directed self-checking bench for seg_scan_driver (SCAN_DIV=4).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] val_i;
  logic        load_i;
  logic        lz_en_i;
  logic        ack_o;
  logic        pend_o;
  logic [6:0]  seg_o;
  logic [3:0]  an_o;

  int n_vec   = 0;
  int n_err   = 0;
  int k       = 0;
  int ack_cnt = 0;

  seg_scan_driver #(
    .SCAN_DIV (4),
    .CNT_W    (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .val_i   (val_i),
    .load_i  (load_i),
    .lz_en_i (lz_en_i),
    .ack_o   (ack_o),
    .pend_o  (pend_o),
    .seg_o   (seg_o),
    .an_o    (an_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (k=%0d)", tag, got, exp, k);
    end
  endtask

  // k counts rising edges since reset release; inputs change on the falling edge.
  task automatic tick();
    @(posedge clk);
    k++;
    @(negedge clk);
    if (ack_o === 1'b1) ack_cnt++;
  endtask

  task automatic run_to(input int t);
    while (k < t) tick();
  endtask

  task automatic chk_digit(input string tag, input int d, input logic [6:0] s);
    logic [3:0] an_exp;
    an_exp = ~(4'b0001 << d);
    chk($sformatf("%s_d%0d", tag, d), {21'd0, an_o, seg_o}, {21'd0, an_exp, s});
  endtask

  // Frame f digit d is on the outputs after edges 16f+4d+1 .. 16f+4d+4.
  task automatic chk_frame(input int f, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int d = 0; d < 4; d++) begin
      run_to(16*f + 4*d + 1);
      chk_digit($sformatf("f%0d_first", f), d, s[d]);
      run_to(16*f + 4*d + 3);
      chk_digit($sformatf("f%0d_hold", f), d, s[d]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    val_i   = 16'h0000;
    load_i  = 1'b0;
    lz_en_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_an",   {28'd0, an_o},   32'hF);
    chk("rst_seg",  {25'd0, seg_o},  32'h7F);
    chk("rst_pend", {31'd0, pend_o}, 32'd0);
    chk("rst_ack",  {31'd0, ack_o},  32'd0);

    rst = 1'b0; k = 0; ack_cnt = 0;
    chk_frame(0, 7'h40, 7'h40, 7'h40, 7'h40);
    chk("f0_no_ack", {31'd0, ack_o}, 32'd0);

    // Double buffering: load during digit 1 of frame 1
    run_to(17);
    chk_digit("f1", 0, 7'h40);
    run_to(22);
    val_i = 16'h12AF; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    chk("dbl_pend", {31'd0, pend_o}, 32'd1);
    run_to(25);
    chk_digit("dbl_wait", 2, 7'h40);
    run_to(29);
    chk_digit("dbl_wait", 3, 7'h40);
    run_to(31);
    chk("dbl_ack", {31'd0, ack_o}, 32'd1);
    tick();
    chk("dbl_pend_clr", {31'd0, pend_o}, 32'd0);
    chk("dbl_ack_off",  {31'd0, ack_o},  32'd0);
    chk("dbl_ack_cnt",  ack_cnt, 32'd1);
    chk_frame(2, 7'h0E, 7'h08, 7'h24, 7'h79);

    // Last load in a frame wins, single ack
    ack_cnt = 0;
    run_to(49);
    val_i = 16'h1111; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    run_to(53);
    val_i = 16'h2222; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    run_to(57);
    chk_digit("lw_old", 2, 7'h24);
    run_to(63);
    chk("lw_ack", {31'd0, ack_o}, 32'd1);
    run_to(64);
    chk("lw_ack_cnt", ack_cnt, 32'd1);
    chk_frame(4, 7'h24, 7'h24, 7'h24, 7'h24);

    // Boundary bypass: k=79 is the index-3 terminal count
    val_i = 16'h00C5; load_i = 1'b1;
    #1;
    chk("byp_ack",  {31'd0, ack_o},  32'd1);
    chk("byp_pend", {31'd0, pend_o}, 32'd0);
    tick();
    load_i = 1'b0;
    chk("byp_pend_after", {31'd0, pend_o}, 32'd0);
    chk("byp_ack_after",  {31'd0, ack_o},  32'd0);
    chk_frame(5, 7'h12, 7'h46, 7'h40, 7'h40);

    // Leading-zero blanking
    lz_en_i = 1'b1;
    chk_frame(6, 7'h12, 7'h46, 7'h7F, 7'h7F);
    val_i = 16'h0000; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    chk_frame(7, 7'h40, 7'h7F, 7'h7F, 7'h7F);

    // Reset mid-frame with a load pending
    run_to(136);
    val_i = 16'h5555; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    chk("mid_pend", {31'd0, pend_o}, 32'd1);
    run_to(138);
    rst = 1'b1;
    #1;
    chk("mid_rst_an",   {28'd0, an_o},   32'hF);
    chk("mid_rst_seg",  {25'd0, seg_o},  32'h7F);
    chk("mid_rst_pend", {31'd0, pend_o}, 32'd0);
    chk("mid_rst_ack",  {31'd0, ack_o},  32'd0);
    @(negedge clk);
    rst = 1'b0; k = 0; ack_cnt = 0;
    chk_frame(0, 7'h40, 7'h7F, 7'h7F, 7'h7F);
    chk_frame(1, 7'h40, 7'h7F, 7'h7F, 7'h7F);
    chk("mid_no_ack", ack_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
